fm_op_eg: RTL and testbench

- Time-multiplexed ADSR envelope-generator engine for the FM operator slots.
- On each sample tick it sweeps slots 0..NUM_SLOTS-1.
- Per slot it reads the stored stage, rate counter and envelope from the per-slot EG state store, advances them by one sample and writes them back.
- It emits the slot's new envelope attenuation to the operator output stage.
- It sits directly upstream of the per-slot EG state RAM: it drives that RAM's index and write-enable and consumes its asynchronous read data.

---
 rtl/fm_op_eg.sv | 234 +++++++++++++++++++++++
 tb/tb_fm_op_eg.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_op_eg.sv
// fm_op_eg: time-multiplexed ADSR envelope generator for the FM operator slots.
// Each sample tick sweeps every slot: RD captures the stored EG state and the
// slot parameters, WR writes the advanced state back and emits the envelope.
module fm_op_eg #(
   parameter int unsigned NUM_SLOTS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_tick,
   output logic [5:0]  o_par_idx,
   input  logic        i_keyon,
   input  logic [3:0]  i_ar,
   input  logic [3:0]  i_dr,
   input  logic [3:0]  i_sl,
   input  logic [3:0]  i_rr,
   output logic [5:0]  o_st_idx,
   output logic        o_st_wren,
   output logic [1:0]  o_st_stage,
   output logic [14:0] o_st_cnt,
   output logic [8:0]  o_st_env,
   input  logic [1:0]  i_st_stage,
   input  logic [14:0] i_st_cnt,
   input  logic [8:0]  i_st_env,
   output logic        o_att_valid,
   output logic [5:0]  o_att_idx,
   output logic [8:0]  o_att,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_overrun
);

   localparam int unsigned IDX_W = 6;
   localparam int unsigned CNT_W = 15;
   localparam int unsigned ENV_W = 9;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
   localparam logic [ENV_W-1:0] ENV_MAX  = 9'd511;

   localparam logic [1:0] STG_ATTACK  = 2'd0;
   localparam logic [1:0] STG_DECAY   = 2'd1;
   localparam logic [1:0] STG_SUSTAIN = 2'd2;
   localparam logic [1:0] STG_RELEASE = 2'd3;

   typedef enum logic [2:0] {S_INIT, S_CLR, S_IDLE, S_RD, S_WR} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pend_q, pend_d;
   logic [ENV_W-1:0]   att_q, att_d;
   logic [IDX_W-1:0]   att_idx_q, att_idx_d;
   logic               att_valid_q, att_valid_d;
   logic               done_q, done_d;
   logic               overrun_q, overrun_d;

   logic [1:0]         stg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ENV_W-1:0]   env_q;
   logic               kon_q;
   logic [3:0]         ar_q, dr_q, sl_q, rr_q;

   logic [1:0]         stg_nxt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [ENV_W-1:0]   env_nxt;
   logic [3:0]         rate;
   logic [15:0]        inc;
   logic [15:0]        sum;
   logic [9:0]         dec;
   logic               busy;
   logic               start_next;

   // Capture the slot's stored state and parameters during RD
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_q <= STG_RELEASE;
         cnt_q <= '0;
         env_q <= ENV_MAX;
         kon_q <= 1'b0;
         ar_q  <= '0;
         dr_q  <= '0;
         sl_q  <= '0;
         rr_q  <= '0;
      end else if (state_q == S_RD) begin
         stg_q <= i_st_stage;
         cnt_q <= i_st_cnt;
         env_q <= i_st_env;
         kon_q <= i_keyon;
         ar_q  <= i_ar;
         dr_q  <= i_dr;
         sl_q  <= i_sl;
         rr_q  <= i_rr;
      end
   end

   // One-sample envelope advance of the captured slot
   always_comb begin
      stg_nxt = stg_q;
      cnt_nxt = cnt_q;
      env_nxt = env_q;
      rate    = 4'd0;
      inc     = 16'd0;
      case (stg_q)
         STG_ATTACK:  rate = ar_q;
         STG_DECAY:   rate = dr_q;
         STG_RELEASE: rate = rr_q;
         default:     rate = 4'd0;
      endcase
      if (rate != 4'd0) inc = 16'(1) << rate;
      sum = {1'b0, cnt_q} + inc;
      dec = 10'(env_q >> 4) + 10'd1;
      if (kon_q && stg_q == STG_RELEASE) begin
         stg_nxt = STG_ATTACK;
         cnt_nxt = '0;
      end else if (!kon_q && stg_q != STG_RELEASE) begin
         stg_nxt = STG_RELEASE;
         cnt_nxt = '0;
      end else if (stg_q != STG_SUSTAIN && rate != 4'd0) begin
         cnt_nxt = sum[CNT_W-1:0];
         if (sum[15]) begin
            if (stg_q == STG_ATTACK)
               env_nxt = (10'(env_q) > dec) ? ENV_W'(10'(env_q) - dec) : '0;
            else if (env_q != ENV_MAX)
               env_nxt = env_q + 9'd1;
         end
         if (stg_q == STG_ATTACK && env_nxt == '0) begin
            stg_nxt = STG_DECAY;
            cnt_nxt = '0;
         end else if (stg_q == STG_DECAY && env_nxt >= {sl_q, 5'b0}) begin
            stg_nxt = STG_SUSTAIN;
            cnt_nxt = '0;
         end
      end
   end

   // Sequencer state, tick bookkeeping and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_INIT;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         att_q       <= ENV_MAX;
         att_idx_q   <= '0;
         att_valid_q <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         att_q       <= att_d;
         att_idx_q   <= att_idx_d;
         att_valid_q <= att_valid_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state, RAM write port and tick arbitration
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pend_d      = pend_q;
      att_d       = att_q;
      att_idx_d   = att_idx_q;
      att_valid_d = 1'b0;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      o_st_wren   = 1'b0;
      o_st_stage  = stg_nxt;
      o_st_cnt    = cnt_nxt;
      o_st_env    = env_nxt;
      busy        = (state_q != S_IDLE);
      start_next  = pend_q | i_tick;

      // A tick arriving while busy is held once; a second one is dropped
      if (busy && i_tick) begin
         if (pend_q) overrun_d = 1'b1;
         else        pend_d    = 1'b1;
      end

      case (state_q)
         S_INIT: begin
            state_d = S_CLR;
            idx_d   = '0;
         end
         S_CLR: begin
            o_st_wren  = 1'b1;
            o_st_stage = STG_RELEASE;
            o_st_cnt   = '0;
            o_st_env   = ENV_MAX;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = start_next ? S_RD : S_IDLE;
               if (start_next) pend_d = 1'b0;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         S_IDLE: begin
            if (i_tick) begin
               state_d = S_RD;
               idx_d   = '0;
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            o_st_wren   = 1'b1;
            att_d       = env_nxt;
            att_idx_d   = idx_q;
            att_valid_d = 1'b1;
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = start_next ? S_RD : S_IDLE;
               if (start_next) pend_d = 1'b0;
            end else begin
               idx_d   = idx_q + 6'd1;
               state_d = S_RD;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   assign o_par_idx   = idx_q;
   assign o_st_idx    = idx_q;
   assign o_busy      = busy;
   assign o_att       = att_q;
   assign o_att_idx   = att_idx_q;
   assign o_att_valid = att_valid_q;
   assign o_done      = done_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_fm_op_eg.sv
// Bench for fm_op_eg: owns the EG state RAM and parameter file, and checks the
// engine against a per-slot envelope reference model.
module tb_fm_op_eg;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_tick;
   logic [5:0]  o_par_idx;
   logic        i_keyon;
   logic [3:0]  i_ar, i_dr, i_sl, i_rr;
   logic [5:0]  o_st_idx;
   logic        o_st_wren;
   logic [1:0]  o_st_stage;
   logic [14:0] o_st_cnt;
   logic [8:0]  o_st_env;
   logic [1:0]  i_st_stage;
   logic [14:0] i_st_cnt;
   logic [8:0]  i_st_env;
   logic        o_att_valid;
   logic [5:0]  o_att_idx;
   logic [8:0]  o_att;
   logic        o_busy, o_done, o_overrun;

   // EG state RAM with asynchronous read and a bench backdoor write port
   logic [1:0]  ram_stage [0:63];
   logic [14:0] ram_cnt   [0:63];
   logic [8:0]  ram_env   [0:63];
   logic        bd_we;
   logic [5:0]  bd_idx;
   logic [1:0]  bd_stage;
   logic [14:0] bd_cnt;
   logic [8:0]  bd_env;

   // Parameter register file
   logic        p_keyon [0:63];
   logic [3:0]  p_ar [0:63];
   logic [3:0]  p_dr [0:63];
   logic [3:0]  p_sl [0:63];
   logic [3:0]  p_rr [0:63];

   // Reference model state
   int m_stage [0:63];
   int m_cnt   [0:63];
   int m_env   [0:63];

   logic [8:0] obs_att [0:63];
   int sw_nvalid, sw_overrun;
   bit sw_done;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign i_st_stage = ram_stage[o_st_idx];
   assign i_st_cnt   = ram_cnt[o_st_idx];
   assign i_st_env   = ram_env[o_st_idx];
   assign i_keyon    = p_keyon[o_par_idx];
   assign i_ar       = p_ar[o_par_idx];
   assign i_dr       = p_dr[o_par_idx];
   assign i_sl       = p_sl[o_par_idx];
   assign i_rr       = p_rr[o_par_idx];

   always @(posedge clk) begin
      if (o_st_wren) begin
         ram_stage[o_st_idx] <= o_st_stage;
         ram_cnt[o_st_idx]   <= o_st_cnt;
         ram_env[o_st_idx]   <= o_st_env;
      end else if (bd_we) begin
         ram_stage[bd_idx] <= bd_stage;
         ram_cnt[bd_idx]   <= bd_cnt;
         ram_env[bd_idx]   <= bd_env;
      end
   end

   fm_op_eg #(.NUM_SLOTS(64)) dut (
      .clk(clk), .reset(reset), .i_tick(i_tick), .o_par_idx(o_par_idx),
      .i_keyon(i_keyon), .i_ar(i_ar), .i_dr(i_dr), .i_sl(i_sl), .i_rr(i_rr),
      .o_st_idx(o_st_idx), .o_st_wren(o_st_wren), .o_st_stage(o_st_stage),
      .o_st_cnt(o_st_cnt), .o_st_env(o_st_env), .i_st_stage(i_st_stage),
      .i_st_cnt(i_st_cnt), .i_st_env(i_st_env), .o_att_valid(o_att_valid),
      .o_att_idx(o_att_idx), .o_att(o_att), .o_busy(o_busy), .o_done(o_done),
      .o_overrun(o_overrun)
   );

   // Envelope rules for one slot over one sample (0 A, 1 D, 2 S, 3 R)
   function automatic void model_slot(int s);
      int st, cnt, env, r;
      st = m_stage[s]; cnt = m_cnt[s]; env = m_env[s];
      if (p_keyon[s] && st == 3) begin
         st = 0; cnt = 0;
      end else if (!p_keyon[s] && st != 3) begin
         st = 3; cnt = 0;
      end else if (st != 2) begin
         r = (st == 0) ? int'(p_ar[s]) : (st == 1) ? int'(p_dr[s]) : int'(p_rr[s]);
         if (r != 0) begin
            cnt = cnt + (1 << r);
            if (cnt >= 32768) begin
               cnt = cnt - 32768;
               if (st == 0) env = (env - env / 16 - 1 < 0) ? 0 : env - env / 16 - 1;
               else         env = (env + 1 > 511) ? 511 : env + 1;
            end
            if (st == 0 && env == 0) begin
               st = 1; cnt = 0;
            end else if (st == 1 && env >= int'(p_sl[s]) * 32) begin
               st = 2; cnt = 0;
            end
         end
      end
      m_stage[s] = st; m_cnt[s] = cnt; m_env[s] = env;
   endfunction

   function automatic void model_sweep();
      for (int s = 0; s < 64; s++) model_slot(s);
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < 64; s++) begin
         m_stage[s] = 3; m_cnt[s] = 0; m_env[s] = 511;
      end
   endfunction

   task automatic rand_params();
      for (int s = 0; s < 64; s++) begin
         p_keyon[s] = ($urandom_range(0, 3) != 0);
         p_ar[s] = 4'($urandom_range(0, 15));
         p_dr[s] = 4'($urandom_range(0, 15));
         p_sl[s] = 4'($urandom_range(0, 15));
         p_rr[s] = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic poke(input int s, input int st, input int cnt, input int env);
      bd_idx = 6'(s); bd_stage = 2'(st); bd_cnt = 15'(cnt); bd_env = 9'(env);
      bd_we = 1'b1;
      @(negedge clk);
      bd_we = 1'b0;
      m_stage[s] = st; m_cnt[s] = cnt; m_env[s] = env;
   endtask

   // Launch one tick and collect the attenuation strobes until o_done
   task automatic run_sweep();
      sw_done = 0; sw_nvalid = 0; sw_overrun = 0;
      for (int s = 0; s < 64; s++) obs_att[s] = 'x;
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
      for (int c = 0; c < 400 && !sw_done; c++) begin
         @(negedge clk);
         if (o_att_valid) begin
            obs_att[o_att_idx] = o_att;
            sw_nvalid++;
         end
         if (o_overrun) sw_overrun++;
         if (o_done) sw_done = 1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int s = 0; s < 64; s++)
         poke(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 32767)), int'($urandom_range(0, 511)));
      checks++;
      if (o_att !== 9'd511 || o_att_idx !== 6'd0 || o_att_valid !== 1'b0 || o_done !== 1'b0 ||
          o_overrun !== 1'b0 || o_busy !== 1'b1 || o_st_wren !== 1'b0) begin
         failures++;
         $display("FAIL reset_values att=%0d idx=%0d valid=%b done=%b ovr=%b busy=%b wren=%b (want 511 0 0 0 0 1 0)",
                  o_att, o_att_idx, o_att_valid, o_done, o_overrun, o_busy, o_st_wren);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (o_st_wren !== 1'b0 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL init_cycle wren=%b busy=%b (want 0 1)", o_st_wren, o_busy);
      end
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         checks++;
         if (o_st_wren !== 1'b1 || o_st_idx !== 6'(k) || o_st_stage !== 2'd3 || o_st_cnt !== 15'd0 ||
             o_st_env !== 9'd511 || o_att_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_cycle k=%0d wren=%b idx=%0d st=%0d cnt=%0d env=%0d valid=%b done=%b",
                     k, o_st_wren, o_st_idx, o_st_stage, o_st_cnt, o_st_env, o_att_valid, o_done);
         end
      end
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_st_wren !== 1'b0) begin
         failures++;
         $display("FAIL busy_fall busy=%b wren=%b (want 0 0)", o_busy, o_st_wren);
      end
      model_clear();
      for (int s = 0; s < 64; s++) begin
         checks++;
         if (ram_stage[s] !== 2'd3 || ram_cnt[s] !== 15'd0 || ram_env[s] !== 9'd511) begin
            failures++;
            $display("FAIL clr_ram slot=%0d st=%0d cnt=%0d env=%0d (want 3 0 511)", s, ram_stage[s], ram_cnt[s], ram_env[s]);
         end
      end
   endtask

   task automatic test_attack();
      int n;
      rand_params();
      p_keyon[5] = 1'b1; p_ar[5] = 4'd15; p_dr[5] = 4'd0;
      for (n = 0; n < 150 && (n < 2 || m_stage[5] == 0); n++) begin
         model_sweep();
         run_sweep();
         checks++;
         if (!sw_done || sw_nvalid != 64) begin
            failures++;
            $display("FAIL attack_sweep n=%0d done=%0d valid=%0d (want 1 64)", n, sw_done, sw_nvalid);
         end
         for (int s = 0; s < 64; s++) begin
            checks++;
            if (obs_att[s] !== 9'(m_env[s])) begin
               failures++;
               $display("FAIL attack_att n=%0d slot=%0d got=%0d exp=%0d", n, s, obs_att[s], m_env[s]);
            end
         end
         if (n == 0) begin
            checks++;
            if (obs_att[5] !== 9'd511 || ram_stage[5] !== 2'd0) begin
               failures++;
               $display("FAIL attack_first att=%0d stage=%0d (want 511 0)", obs_att[5], ram_stage[5]);
            end
         end
         if (n == 1) begin
            checks++;
            if (obs_att[5] !== 9'd479) begin
               failures++;
               $display("FAIL attack_second att=%0d (want 479)", obs_att[5]);
            end
         end
      end
      checks++;
      if (ram_env[5] !== 9'd0 || ram_stage[5] !== 2'd1) begin
         failures++;
         $display("FAIL attack_to_decay env=%0d stage=%0d (want 0 1)", ram_env[5], ram_stage[5]);
      end
   endtask

   task automatic test_decay_sustain();
      int exp_env [3] = '{63, 64, 64};
      int exp_st  [3] = '{1, 2, 2};
      poke(7, 1, 0, 62);
      p_keyon[7] = 1'b1; p_dr[7] = 4'd15; p_sl[7] = 4'd2;
      for (int n = 0; n < 3; n++) begin
         model_sweep();
         run_sweep();
         checks++;
         if (obs_att[7] !== 9'(exp_env[n]) || ram_stage[7] !== 2'(exp_st[n])) begin
            failures++;
            $display("FAIL decay_sustain n=%0d att=%0d stage=%0d (want %0d %0d)",
                     n, obs_att[7], ram_stage[7], exp_env[n], exp_st[n]);
         end
      end
   endtask

   task automatic test_release();
      int exp_cnt [3] = '{0, 16384, 0};
      int exp_env [3] = '{64, 64, 65};
      poke(9, 2, 0, 64);
      p_keyon[9] = 1'b0; p_rr[9] = 4'd14;
      for (int n = 0; n < 3; n++) begin
         model_sweep();
         run_sweep();
         checks++;
         if (ram_stage[9] !== 2'd3 || ram_cnt[9] !== 15'(exp_cnt[n]) || obs_att[9] !== 9'(exp_env[n])) begin
            failures++;
            $display("FAIL release n=%0d stage=%0d cnt=%0d att=%0d (want 3 %0d %0d)",
                     n, ram_stage[9], ram_cnt[9], obs_att[9], exp_cnt[n], exp_env[n]);
         end
      end
      poke(9, 3, 0, 510);
      p_rr[9] = 4'd15;
      for (int n = 0; n < 2; n++) begin
         model_sweep();
         run_sweep();
         checks++;
         if (obs_att[9] !== 9'd511 || ram_cnt[9] !== 15'd0) begin
            failures++;
            $display("FAIL release_sat n=%0d att=%0d cnt=%0d (want 511 0)", n, obs_att[9], ram_cnt[9]);
         end
      end
   endtask

   task automatic test_random(input int sweeps);
      for (int n = 0; n < sweeps; n++) begin
         rand_params();
         model_sweep();
         run_sweep();
         checks++;
         if (!sw_done || sw_nvalid != 64 || sw_overrun != 0) begin
            failures++;
            $display("FAIL random_sweep n=%0d done=%0d valid=%0d ovr=%0d (want 1 64 0)", n, sw_done, sw_nvalid, sw_overrun);
         end
         for (int s = 0; s < 64; s++) begin
            checks++;
            if (obs_att[s] !== 9'(m_env[s]) || ram_stage[s] !== 2'(m_stage[s]) ||
                ram_cnt[s] !== 15'(m_cnt[s]) || ram_env[s] !== 9'(m_env[s])) begin
               failures++;
               $display("FAIL random_slot n=%0d slot=%0d att=%0d st=%0d cnt=%0d env=%0d exp=%0d/%0d/%0d",
                        n, s, obs_att[s], ram_stage[s], ram_cnt[s], ram_env[s], m_stage[s], m_cnt[s], m_env[s]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n_done = 0, n_ovr = 0, n_valid = 0;
      rand_params();
      model_sweep();
      model_sweep();
      for (int c = 0; c < 2 * 128 + 40; c++) begin
         i_tick = (c == 0 || c == 5 || c == 10);
         @(negedge clk);
         if (o_att_valid) begin
            obs_att[o_att_idx] = o_att;
            n_valid++;
         end
         if (o_done) n_done++;
         if (o_overrun) n_ovr++;
      end
      i_tick = 1'b0;
      checks++;
      if (n_done != 2 || n_ovr != 1 || n_valid != 128 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL back_to_back done=%0d ovr=%0d valid=%0d busy=%b (want 2 1 128 0)", n_done, n_ovr, n_valid, o_busy);
      end
      for (int s = 0; s < 64; s++) begin
         checks++;
         if (obs_att[s] !== 9'(m_env[s]) || ram_stage[s] !== 2'(m_stage[s]) || ram_cnt[s] !== 15'(m_cnt[s])) begin
            failures++;
            $display("FAIL b2b_slot slot=%0d att=%0d st=%0d cnt=%0d exp=%0d/%0d/%0d",
                     s, obs_att[s], ram_stage[s], ram_cnt[s], m_env[s], m_stage[s], m_cnt[s]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 0;
      int n_done = 0;
      rand_params();
      i_tick = 1'b1;
      @(negedge clk);
      i_tick = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk);
         if (o_st_wren && o_st_idx == 6'd10) hit = 1;
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL mid_reset_wait no WR of slot 10 within budget");
      end
      reset = 1'b1;
      #1;
      checks++;
      if (o_att !== 9'd511 || o_att_idx !== 6'd0 || o_att_valid !== 1'b0 || o_done !== 1'b0 ||
          o_busy !== 1'b1 || o_st_wren !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_values att=%0d idx=%0d valid=%b done=%b busy=%b wren=%b",
                  o_att, o_att_idx, o_att_valid, o_done, o_busy, o_st_wren);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (o_done) n_done++;
         checks++;
         if (o_st_wren !== 1'b1 || o_st_idx !== 6'(k) || o_st_env !== 9'd511 || o_st_stage !== 2'd3) begin
            failures++;
            $display("FAIL mid_reset_clr k=%0d wren=%b idx=%0d env=%0d st=%0d", k, o_st_wren, o_st_idx, o_st_env, o_st_stage);
         end
      end
      @(negedge clk);
      if (o_done) n_done++;
      checks++;
      if (n_done != 0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_end done_pulses=%0d busy=%b (want 0 0)", n_done, o_busy);
      end
      model_clear();
   endtask

   initial begin
      reset = 1'b1; i_tick = 1'b0; bd_we = 1'b0;
      bd_idx = '0; bd_stage = '0; bd_cnt = '0; bd_env = '0;
      for (int s = 0; s < 64; s++) begin
         p_keyon[s] = 1'b0; p_ar[s] = '0; p_dr[s] = '0; p_sl[s] = '0; p_rr[s] = '0;
      end
      @(negedge clk);
      test_reset();
      test_attack();
      test_decay_sustain();
      test_release();
      test_random(6);
      test_back_to_back();
      test_reset_mid();
      test_random(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
